program_counter: RTL and testbench

8-bit registered program counter for the CPU datapath. On every rising clock edge it captures the next-address bus from the fetch/branch logic and presents it as the current instruction address to instruction memory. It also provides sequencing status (previous address, change and sequential-fetch flags) for the control unit and debug logic.

---
 rtl/program_counter_pkg.sv | 16 +
 rtl/program_counter_history.sv | 33 +++
 rtl/program_counter.sv | 74 +++++++
 tb/tb_program_counter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// -----------------------------------------------------------------------------
// program_counter_pkg
// Shared CPU definitions used by the program counter and its history helper.
//   ADDR_W   : instruction address width in bits
//   PC_RESET : address presented while the CPU is held in reset
//   pc_t     : address type, ADDR_W bits wide
// -----------------------------------------------------------------------------
package program_counter_pkg;

  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] pc_t;

  localparam pc_t PC_RESET = 8'h00;

endpackage : program_counter_pkg

// File: rtl/program_counter_history.sv
// -----------------------------------------------------------------------------
// pc_history
// Four-deep shift register holding the last four loaded program-counter
// values. The newest entry sits in hist[WIDTH-1:0], and older entries move
// up by one WIDTH-bit slot on every edge while out of reset.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears every entry to RESET_VALUE
//   load  : value being loaded into the program counter on this edge
//   hist  : packed history {oldest, ..., newest}
// -----------------------------------------------------------------------------
module pc_history
  import program_counter_pkg::*;
#(
  parameter int              WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   load,
  output logic [4*WIDTH-1:0] hist
);

  // Shift history up by one slot and insert the new load at the bottom.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= {4{RESET_VALUE}};
    end else begin
      hist <= {hist[3*WIDTH-1:0], load};
    end
  end

endmodule : pc_history

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Registered program counter. Captures the next-address bus on every rising
// clock edge and presents it to instruction memory, along with sequencing
// status for the control unit and debug logic.
// Ports:
//   in       : next program-counter value from fetch/branch logic
//   clk      : clock, rising edge
//   out      : current program-counter value (registered)
//   rst_n    : asynchronous active-low reset
//   prev_out : value out held before the most recent edge
//   changed  : most recent load differed from the previous out
//   seq      : most recent load equalled previous out + 1 (mod 2^WIDTH)
//   hist     : last four out values, newest in [WIDTH-1:0]
//              (present only when PC_HISTORY_EN is defined)
// Port order keeps the legacy positional form (in, clk, out) working.
// -----------------------------------------------------------------------------
module program_counter
  import program_counter_pkg::*;
#(
  parameter int               WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic [WIDTH-1:0]   in,
  input  logic               clk,
  output logic [WIDTH-1:0]   out,
  input  logic               rst_n,
  output logic [WIDTH-1:0]   prev_out,
  output logic               changed,
`ifdef PC_HISTORY_EN
  output logic               seq,
  output logic [4*WIDTH-1:0] hist
`else
  output logic               seq
`endif
);

  // Successor of the current address; the carry out of the top bit is
  // dropped so 'hFF -> 'h00 counts as a sequential fetch.
  logic [WIDTH-1:0] out_plus_one;

  // Compute the wrapped successor of the current address.
  always_comb begin
    out_plus_one = out + WIDTH'(1);
  end

  // Main address register and sequencing flags, all updated together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= RESET_VALUE;
      prev_out <= RESET_VALUE;
      changed  <= 1'b0;
      seq      <= 1'b0;
    end else begin
      prev_out <= out;
      out      <= in;
      changed  <= (in != out);
      seq      <= (in == out_plus_one);
    end
  end

`ifdef PC_HISTORY_EN
  pc_history #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_pc_history (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (in),
    .hist  (hist)
  );
`endif

endmodule : program_counter

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
// Directed self-checking bench for program_counter. Inputs are driven on the
// falling edge and outputs sampled on the following falling edge, so each
// load() call covers exactly one rising edge. History checks are compiled in
// when PC_HISTORY_EN is defined.
// -----------------------------------------------------------------------------
module tb_program_counter;

  logic       clk;
  logic       rst_n;
  logic [7:0] pc_in;
  logic [7:0] pc_out;
  logic [7:0] prev_out;
  logic       changed;
  logic       seq;
`ifdef PC_HISTORY_EN
  logic [31:0] hist;
`endif

  int checks;
  int errors;

  program_counter dut (
    .in       (pc_in),
    .clk      (clk),
    .out      (pc_out),
    .rst_n    (rst_n),
    .prev_out (prev_out),
    .changed  (changed),
`ifdef PC_HISTORY_EN
    .seq      (seq),
    .hist     (hist)
`else
    .seq      (seq)
`endif
  );

  // 10 ns clock, first rising edge at 5 ns
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Drive a value, let one rising edge take it, return at the next falling edge.
  task automatic load(input logic [7:0] v);
    pc_in = v;
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    // Reset held with no clock edge yet
    rst_n = 1'b0;
    pc_in = 8'd77;
    #1;
    check("rst_out",      {24'd0, pc_out},   32'd0);
    check("rst_prev",     {24'd0, prev_out}, 32'd0);
    check("rst_changed",  {31'd0, changed},  32'd0);
    check("rst_seq",      {31'd0, seq},      32'd0);

    // Release reset between edges
    @(negedge clk);
    rst_n = 1'b1;

    // Basic load: 55 for five edges
    load(8'd55);
    check("load55_out",     {24'd0, pc_out},   32'd55);
    check("load55_prev",    {24'd0, prev_out}, 32'd0);
    check("load55_changed", {31'd0, changed},  32'd1);
    check("load55_seq",     {31'd0, seq},      32'd0);
    load(8'd55);
    check("hold55_changed", {31'd0, changed},  32'd0);
    check("hold55_seq",     {31'd0, seq},      32'd0);
    check("hold55_prev",    {24'd0, prev_out}, 32'd55);
    load(8'd55);
    load(8'd55);
    load(8'd55);

    // Then 200 for five edges
    load(8'd200);
    check("load200_out",     {24'd0, pc_out},   32'd200);
    check("load200_prev",    {24'd0, prev_out}, 32'd55);
    check("load200_changed", {31'd0, changed},  32'd1);
    load(8'd200);
    check("hold200_changed", {31'd0, changed},  32'd0);
    load(8'd200);
    load(8'd200);
    load(8'd200);

    // Sequential stepping
    load(8'd10);
    check("seq10_seq",     {31'd0, seq},     32'd0);
    check("seq10_changed", {31'd0, changed}, 32'd1);
    load(8'd11);
    check("seq11_seq",     {31'd0, seq},     32'd1);
    load(8'd12);
    check("seq12_seq",     {31'd0, seq},     32'd1);
    check("seq12_out",     {24'd0, pc_out},  32'd12);
    load(8'd40);
    check("jump40_seq",     {31'd0, seq},     32'd0);
    check("jump40_changed", {31'd0, changed}, 32'd1);

    // Wrap 255 -> 0 counts as sequential
    load(8'd255);
    check("pre_wrap_out", {24'd0, pc_out}, 32'd255);
    load(8'd0);
    check("wrap_seq",  {31'd0, seq},     32'd1);
    check("wrap_out",  {24'd0, pc_out},  32'd0);
    check("wrap_prev", {24'd0, prev_out}, 32'd255);
    // Same value again: no change, not sequential
    load(8'd0);
    check("same0_changed", {31'd0, changed}, 32'd0);
    check("same0_seq",     {31'd0, seq},     32'd0);

    // Asynchronous reset mid-run
    load(8'd200);
    check("pre_rst_out", {24'd0, pc_out}, 32'd200);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out",     {24'd0, pc_out},   32'd0);
    check("arst_prev",    {24'd0, prev_out}, 32'd0);
    check("arst_changed", {31'd0, changed},  32'd0);
    check("arst_seq",     {31'd0, seq},      32'd0);
    @(negedge clk);
    check("arst_held_out", {24'd0, pc_out}, 32'd0);
    rst_n = 1'b1;
    load(8'd9);
    check("post_rst_out",     {24'd0, pc_out},   32'd9);
    check("post_rst_prev",    {24'd0, prev_out}, 32'd0);
    check("post_rst_changed", {31'd0, changed},  32'd1);

`ifdef PC_HISTORY_EN
    load(8'd1);
    load(8'd2);
    load(8'd3);
    load(8'd4);
    load(8'd5);
    check("hist_12345", hist, {8'd2, 8'd3, 8'd4, 8'd5});
    rst_n = 1'b0;
    #1;
    check("hist_reset", hist, 32'd0);
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_program_counter
